// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin APB master: arbitrates, drives SETUP/ACCESS, returns
// read data and error status, and aborts transfers whose slave never answers.
module apb_arbiter_master #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [2:0]        prot0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [2:0]        prot1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [2:0]        pprot,
   input  logic              pready,
   input  logic              pslverr,
   input  logic [DATA_W-1:0] prdata
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e r_state, w_state_next;

   logic              r_psel, r_penable, r_pwrite, r_last_gnt;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata, r_rdata0, r_rdata1;
   logic [2:0]        r_pprot;
   logic              r_gnt0, r_gnt1, r_done0, r_done1, r_err0, r_err1;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_psel_next, w_penable_next, w_pwrite_next, w_last_gnt_next;
   logic [ADDR_W-1:0] w_paddr_next;
   logic [DATA_W-1:0] w_pwdata_next, w_rdata0_next, w_rdata1_next;
   logic [2:0]        w_pprot_next;
   logic              w_gnt0_next, w_gnt1_next, w_done0_next, w_done1_next;
   logic              w_err0_next, w_err1_next;
   logic [CNT_W-1:0]  w_cnt_next;

   // A requester is masked in the cycle its done pulse is visible.
   logic w_req0, w_req1, w_any, w_win, w_timeout;
   assign w_req0    = req0 & ~r_done0;
   assign w_req1    = req1 & ~r_done1;
   assign w_any     = w_req0 | w_req1;
   assign w_win     = (w_req0 & w_req1) ? ~r_last_gnt : w_req1;
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (w_any) w_state_next = StSetup;
         StSetup:  w_state_next = StAccess;
         StAccess: if (pready || w_timeout) w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_psel_next     = r_psel;
      w_penable_next  = r_penable;
      w_pwrite_next   = r_pwrite;
      w_paddr_next    = r_paddr;
      w_pwdata_next   = r_pwdata;
      w_pprot_next    = r_pprot;
      w_last_gnt_next = r_last_gnt;
      w_rdata0_next   = r_rdata0;
      w_rdata1_next   = r_rdata1;
      w_err0_next     = r_err0;
      w_err1_next     = r_err1;
      w_cnt_next      = r_cnt;
      w_gnt0_next     = 1'b0;
      w_gnt1_next     = 1'b0;
      w_done0_next    = 1'b0;
      w_done1_next    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_any) begin
               w_psel_next     = 1'b1;
               w_last_gnt_next = w_win;
               w_gnt0_next     = ~w_win;
               w_gnt1_next     = w_win;
               w_pwrite_next   = w_win ? wr1    : wr0;
               w_paddr_next    = w_win ? addr1  : addr0;
               w_pwdata_next   = w_win ? wdata1 : wdata0;
               w_pprot_next    = w_win ? prot1  : prot0;
            end
         end
         StSetup: begin
            w_penable_next = 1'b1;
            w_cnt_next     = '0;
         end
         StAccess: begin
            if (pready || w_timeout) begin
               w_psel_next    = 1'b0;
               w_penable_next = 1'b0;
               // r_last_gnt identifies the owner of the transfer in flight.
               if (r_last_gnt) begin
                  w_done1_next = 1'b1;
                  w_err1_next  = pready ? pslverr : 1'b1;
                  if (!pready)       w_rdata1_next = '0;
                  else if (!r_pwrite) w_rdata1_next = prdata;
               end else begin
                  w_done0_next = 1'b1;
                  w_err0_next  = pready ? pslverr : 1'b1;
                  if (!pready)       w_rdata0_next = '0;
                  else if (!r_pwrite) w_rdata0_next = prdata;
               end
            end else if (TIMEOUT != 0 && r_cnt != CNT_W'(TIMEOUT)) begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_pprot    <= '0;
         r_last_gnt <= 1'b1;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_cnt      <= '0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
      end else begin
         r_psel     <= w_psel_next;
         r_penable  <= w_penable_next;
         r_pwrite   <= w_pwrite_next;
         r_paddr    <= w_paddr_next;
         r_pwdata   <= w_pwdata_next;
         r_pprot    <= w_pprot_next;
         r_last_gnt <= w_last_gnt_next;
         r_rdata0   <= w_rdata0_next;
         r_rdata1   <= w_rdata1_next;
         r_err0     <= w_err0_next;
         r_err1     <= w_err1_next;
         r_cnt      <= w_cnt_next;
         r_gnt0     <= w_gnt0_next;
         r_gnt1     <= w_gnt1_next;
         r_done0    <= w_done0_next;
         r_done1    <= w_done1_next;
      end
   end

   assign psel    = r_psel;
   assign penable = r_penable;
   assign pwrite  = r_pwrite;
   assign paddr   = r_paddr;
   assign pwdata  = r_pwdata;
   assign pprot   = r_pprot;
   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign done0   = r_done0;
   assign done1   = r_done1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;
   assign err0    = r_err0;
   assign err1    = r_err1;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: directed transfer table, reset/round-robin sequence,
// then randomized traffic checked against a transaction-level reference model.
module tb_apb_arbiter_master;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic        req [2];
   logic        wr  [2];
   logic [4:0]  addr [2];
   logic [31:0] wdata [2];
   logic [2:0]  prot [2];
   logic        gnt [2];
   logic        done [2];
   logic [31:0] rdata [2];
   logic        err [2];
   logic        psel, penable, pwrite, pready, pslverr;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic [2:0]  pprot;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   apb_arbiter_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .wr0(wr[0]), .addr0(addr[0]), .wdata0(wdata[0]), .prot0(prot[0]),
      .req1(req[1]), .wr1(wr[1]), .addr1(addr[1]), .wdata1(wdata[1]), .prot1(prot[1]),
      .gnt0(gnt[0]), .gnt1(gnt[1]), .done0(done[0]), .done1(done[1]),
      .rdata0(rdata[0]), .rdata1(rdata[1]), .err0(err[0]), .err1(err[1]),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pprot(pprot), .pready(pready), .pslverr(pslverr), .prdata(prdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        who;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  prot;
      int          waits;
      logic        slverr;
      logic [31:0] prdata;
      int          exp_done;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      int    done_edge;
      string tag;
      tag = $sformatf("vec(addr=%0h)", v.addr);
      req[v.who] = 1'b1; wr[v.who] = v.wr; addr[v.who] = v.addr;
      wdata[v.who] = v.wdata; prot[v.who] = v.prot;
      pslverr = v.slverr; prdata = v.prdata;
      done_edge = -1;
      for (int k = 0; k < 20 && done_edge < 0; k++) begin
         pready = (k >= 2 + v.waits);
         @(posedge clk); #1;
         if (k == 0) begin
            chk({tag, " psel@E0"}, psel, 1);
            chk({tag, " gnt@E0"}, gnt[v.who], 1);
         end
         if (k == 1) chk({tag, " penable@E1"}, penable, 1);
         chk({tag, " paddr"}, paddr, v.addr);
         chk({tag, " pwrite"}, pwrite, v.wr);
         chk({tag, " pprot"}, pprot, v.prot);
         if (v.wr) chk({tag, " pwdata"}, pwdata, v.wdata);
         if (done[v.who]) done_edge = k;
      end
      chk({tag, " done edge"}, done_edge, v.exp_done);
      chk({tag, " err"}, err[v.who], v.exp_err);
      chk({tag, " rdata"}, rdata[v.who], v.exp_rdata);
      chk({tag, " psel after done"}, {psel, penable}, 0);
      req[v.who] = 1'b0; pready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: one transfer in flight, tracked by edges since grant.
   logic        m_busy, m_owner, m_last, m_psel, m_pen, m_pwrite;
   logic [4:0]  m_paddr;
   logic [31:0] m_pwdata;
   logic [2:0]  m_pprot;
   logic [1:0]  m_gnt, m_done, m_err;
   logic [31:0] m_rdata [2];
   int          m_age, m_lows;

   task automatic model_reset();
      m_busy = 0; m_last = 1; m_psel = 0; m_pen = 0; m_pwrite = 0; m_paddr = 0;
      m_pwdata = 0; m_pprot = 0; m_gnt = 0; m_done = 0; m_err = 0;
      m_rdata[0] = 0; m_rdata[1] = 0; m_owner = 0; m_age = 0; m_lows = 0;
   endtask

   task automatic model_step();
      logic [1:0] elig;
      logic       w;
      elig = {req[1] & ~m_done[1], req[0] & ~m_done[0]};
      m_gnt = 0; m_done = 0;
      if (!m_busy) begin
         if (elig != 0) begin
            w = (elig == 2'b11) ? !m_last : elig[1];
            m_busy = 1; m_age = 0; m_owner = w; m_last = w; m_psel = 1; m_gnt[w] = 1;
            m_pwrite = wr[w]; m_paddr = addr[w]; m_pwdata = wdata[w]; m_pprot = prot[w];
         end
      end else if (m_age == 0) begin
         m_pen = 1; m_age = 1; m_lows = 0;
      end else if (pready) begin
         m_done[m_owner] = 1; m_err[m_owner] = pslverr;
         if (!m_pwrite) m_rdata[m_owner] = prdata;
         m_psel = 0; m_pen = 0; m_busy = 0;
      end else begin
         m_lows++;
         if (m_lows > TO) begin
            m_done[m_owner] = 1; m_err[m_owner] = 1; m_rdata[m_owner] = 0;
            m_psel = 0; m_pen = 0; m_busy = 0;
         end
      end
   endtask

   task automatic new_req(input int n);
      req[n] = 1'b1; wr[n] = 1'($urandom); addr[n] = 5'($urandom);
      wdata[n] = $urandom; prot[n] = 3'($urandom);
   endtask

   int          g_edge [$];
   int          g_id [$];
   int          exp_id [4];

   initial begin
      vecs[0] = '{0, 1, 5'h0A, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0, 2, 0, 32'h0};
      vecs[1] = '{1, 0, 5'h03, 32'h0, 3'd0, 3, 0, 32'h12345678, 5, 0, 32'h12345678};
      vecs[2] = '{0, 0, 5'h1F, 32'h0, 3'd5, 1, 1, 32'hCAFEF00D, 3, 1, 32'hCAFEF00D};
      vecs[3] = '{0, 1, 5'h11, 32'h55AA55AA, 3'd1, 99, 0, 32'h0, 6, 1, 32'h0};
      vecs[4] = '{1, 0, 5'h07, 32'h0, 3'd7, 0, 0, 32'hA5A5A5A5, 2, 0, 32'hA5A5A5A5};
      vecs[5] = '{1, 1, 5'h10, 32'h01234567, 3'd3, 2, 0, 32'hFFFFFFFF, 4, 0, 32'hA5A5A5A5};
      for (int n = 0; n < 2; n++) begin
         req[n] = 0; wr[n] = 0; addr[n] = 0; wdata[n] = 0; prot[n] = 0;
      end
      pready = 0; pslverr = 0; prdata = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset bus", {psel, penable, pwrite, paddr, pprot}, 0);
      chk("reset pwdata", pwdata, 0);
      chk("reset gnt/done/err", {gnt[0], gnt[1], done[0], done[1], err[0], err[1]}, 0);
      chk("reset rdata", {rdata[0], rdata[1]}, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset killed mid-ACCESS, then tie-break and round-robin from reset.
      new_req(0); wr[0] = 0; pready = 0;
      repeat (4) @(posedge clk);
      @(negedge clk); rst = 1; #1;
      chk("async reset bus", {psel, penable, pwrite, paddr, pprot, pwdata}, 0);
      chk("async reset status",
          {gnt[0], gnt[1], done[0], done[1], err[0], err[1], rdata[0], rdata[1]}, 0);
      new_req(1); pready = 1;
      @(negedge clk); rst = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (gnt[0] && done[0]) chk("regrant in own done cycle 0", 1, 0);
         if (gnt[1] && done[1]) chk("regrant in own done cycle 1", 1, 0);
         if (gnt[0] || gnt[1]) begin g_edge.push_back(k); g_id.push_back(gnt[1] ? 1 : 0); end
      end
      exp_id = '{0, 1, 0, 1};
      chk("rr grant count", g_edge.size(), 4);
      for (int i = 0; i < 4 && i < g_edge.size(); i++) begin
         chk($sformatf("rr grant %0d id", i), g_id[i], exp_id[i]);
         chk($sformatf("rr grant %0d edge", i), g_edge[i], 3 * i);
      end

      // Randomized traffic against the reference model.
      req[0] = 0; req[1] = 0; pready = 0;
      @(negedge clk); rst = 1; @(negedge clk); rst = 0;
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int n = 0; n < 2; n++) if (!req[n] && $urandom_range(0, 3) == 0) new_req(n);
         pready = ($urandom_range(0, 9) < 6);
         pslverr = ($urandom_range(0, 3) == 0);
         prdata = $urandom;
         model_step();
         @(posedge clk); #1;
         chk("rnd psel/penable", {psel, penable}, {m_psel, m_pen});
         chk("rnd gnt", {gnt[1], gnt[0]}, m_gnt);
         chk("rnd done", {done[1], done[0]}, m_done);
         chk("rnd err", {err[1], err[0]}, m_err);
         chk("rnd rdata0", rdata[0], m_rdata[0]);
         chk("rnd rdata1", rdata[1], m_rdata[1]);
         if (m_psel) begin
            chk("rnd pwrite/paddr/pprot", {pwrite, paddr, pprot}, {m_pwrite, m_paddr, m_pprot});
            chk("rnd pwdata", pwdata, m_pwdata);
         end
         for (int n = 0; n < 2; n++) begin
            if (m_done[n]) begin
               if ($urandom_range(0, 1) == 0) req[n] = 0;
               else new_req(n);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
